// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder.
// The master drives the operands and in_valid; the slave (the adder)
// returns the registered sum, carry and out_valid.
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    input  sum,
    input  carry,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    output sum,
    output carry,
    output out_valid
  );
endinterface : full_adder_if

// File: rtl/full_adder.sv
// Registered ripple-carry adder built from 1-bit full-adder cells.
// {carry, sum} = a + b + cin is captured on every edge where in_valid is
// high and appears one cycle later with a single-cycle out_valid pulse.
// While in_valid is low the previous result is held, so operands may be
// anything (including X) without disturbing the outputs.
// WIDTH must be at least 1; WIDTH=1 is the classic single-bit full adder.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);

  // One full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] fa_cell(
    input logic a_i,
    input logic b_i,
    input logic c_i
  );
    logic s_v;
    logic co_v;
    s_v  = a_i ^ b_i ^ c_i;
    co_v = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    return {co_v, s_v};
  endfunction

  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             out_valid_r;

  // Ripple the carry through every cell within a single cycle.
  always_comb begin
    logic       c_v;
    logic [1:0] cell_v;
    sum_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    c_v     = bus.cin;
    cell_v  = 2'b00;
    for (int i = 0; i < WIDTH; i++) begin
      cell_v   = fa_cell(bus.a[i], bus.b[i], c_v);
      sum_s[i] = cell_v[0];
      c_v      = cell_v[1];
    end
    carry_s = c_v;
  end

  // Result registers: reset clears, accepted input loads, idle holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      sum_r       <= sum_s;
      carry_r     <= carry_s;
      out_valid_r <= 1'b1;
    end else begin
      sum_r       <= sum_r;
      carry_r     <= carry_r;
      out_valid_r <= 1'b0;
    end
  end

  assign bus.sum       = sum_r;
  assign bus.carry     = carry_r;
  assign bus.out_valid = out_valid_r;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed and scoreboard checks for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  logic clk;
  logic rst1;
  logic rst8;
  int   errors;
  int   checks;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    rst1 = 1'b1;
    tick();
    checks++;
    if ({bus1.carry, bus1.sum, bus1.out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_clear: got carry,sum,valid=%b%b%b want 000",
               bus1.carry, bus1.sum, bus1.out_valid);
    end
    rst1 = 1'b0;
    tick();
    checks++;
    if ({bus1.carry, bus1.sum, bus1.out_valid} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release: got carry,sum,valid=%b%b%b want 111",
               bus1.carry, bus1.sum, bus1.out_valid);
    end
  endtask

  task automatic test_truth_table();
    logic [7:0] exp_sum;
    logic [7:0] exp_carry;
    logic [2:0] row;
    // rows 000..111 -> sum 0,1,1,0,1,0,0,1 ; carry 0,0,0,1,0,1,1,1
    exp_sum   = 8'b1001_0110;
    exp_carry = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      row = 3'(i);
      bus1.a = row[2]; bus1.b = row[1]; bus1.cin = row[0];
      bus1.in_valid = 1'b1;
      tick();
      checks++;
      if (bus1.sum !== exp_sum[i] || bus1.carry !== exp_carry[i] ||
          bus1.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL truth_row_%b: got sum=%b carry=%b valid=%b want sum=%b carry=%b valid=1",
                 row, bus1.sum, bus1.carry, bus1.out_valid, exp_sum[i], exp_carry[i]);
      end
    end
  endtask

  task automatic test_hold();
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b0; bus1.in_valid = 1'b1;
    tick();
    checks++;
    if ({bus1.carry, bus1.sum, bus1.out_valid} !== 3'b011) begin
      errors++;
      $display("FAIL hold_capture: got carry,sum,valid=%b%b%b want 011",
               bus1.carry, bus1.sum, bus1.out_valid);
    end
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus1.carry, bus1.sum, bus1.out_valid} !== 3'b010) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got carry,sum,valid=%b%b%b want 010",
                 i, bus1.carry, bus1.sum, bus1.out_valid);
      end
    end
  endtask

  task automatic test_boundary8();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vc [3];
    logic [8:0] ve [3];
    va[0] = 8'hFF; vb[0] = 8'h00; vc[0] = 1'b1; ve[0] = 9'h100;
    va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1'b1; ve[1] = 9'h1FF;
    va[2] = 8'h00; vb[2] = 8'h00; vc[2] = 1'b0; ve[2] = 9'h000;
    for (int i = 0; i < 3; i++) begin
      bus8.a = va[i]; bus8.b = vb[i]; bus8.cin = vc[i]; bus8.in_valid = 1'b1;
      tick();
      checks++;
      if ({bus8.carry, bus8.sum} !== ve[i] || bus8.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL boundary8_%0d: got carry,sum=%h valid=%b want %h valid=1",
                 i, {bus8.carry, bus8.sum}, bus8.out_valid, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        bus1.a = 1'b0; bus1.b = 1'b1; bus1.cin = 1'b1;
      end else begin
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b0;
      end
      bus1.in_valid = 1'b1;
      tick();
      checks++;
      if (bus1.sum !== 1'b0 || bus1.carry !== 1'b1 || bus1.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got sum=%b carry=%b valid=%b want sum=0 carry=1 valid=1",
                 i, bus1.sum, bus1.carry, bus1.out_valid);
      end
    end
    bus1.in_valid = 1'b0;
    tick();
    checks++;
    if (bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_drop: got valid=%b want 0", bus1.out_valid);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_res;
    logic       exp_valid;
    exp_res   = {bus8.carry, bus8.sum};
    exp_valid = bus8.out_valid;
    for (int i = 0; i < 1000; i++) begin
      rst8          = ($urandom_range(0, 49) == 0);
      bus8.in_valid = ($urandom_range(0, 3) != 0);
      bus8.a        = 8'($urandom);
      bus8.b        = 8'($urandom);
      bus8.cin      = 1'($urandom);
      if (rst8) begin
        exp_res   = 9'h000;
        exp_valid = 1'b0;
      end else if (bus8.in_valid) begin
        exp_res   = {1'b0, bus8.a} + {1'b0, bus8.b} + {8'h00, bus8.cin};
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      tick();
      checks++;
      if ({bus8.carry, bus8.sum} !== exp_res || bus8.out_valid !== exp_valid) begin
        errors++;
        $display("FAIL random_%0d: got carry,sum=%h valid=%b want %h valid=%b",
                 i, {bus8.carry, bus8.sum}, bus8.out_valid, exp_res, exp_valid);
      end
    end
    rst8 = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst1 = 1'b1;
    rst8 = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus8.carry, bus8.sum} !== 9'h000 || bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset8: got carry,sum=%h valid=%b want 000 valid=0",
               {bus8.carry, bus8.sum}, bus8.out_valid);
    end
    rst8 = 1'b0;
    test_reset();
    test_truth_table();
    test_hold();
    test_boundary8();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_full_adder

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder: adds operands a and b plus carry-in cin, producing sum and carry-out one clock after the inputs are accepted.
- Default WIDTH=1 gives the classic single-bit full adder (8-row truth table). Larger WIDTH gives a ripple-carry chain of 1-bit full-adder cells.
- Used as a leaf arithmetic primitive in datapaths that need a registered, valid-qualified add.

Parameters:
- WIDTH, 1, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  qualifies a, b and cin for capture on this clock edge
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in into bit 0
- sum  output  WIDTH  registered sum bits
- carry  output  1  registered carry-out of the MSB cell
- out_valid  output  1  high for exactly one cycle per accepted input, aligned with sum/carry

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state changes happen on the rising edge of clk only.
- Cell equations, for bit i with c0 = cin:
  - s_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (a_i & b_i) | (a_i & c_i) | (b_i & c_i)
  - carry = c_WIDTH.
  - Carry ripples combinationally through all cells within one cycle; there is no internal pipelining.
- Arithmetic: {carry, sum} equals a + b + cin, computed exactly at WIDTH+1 bits. No overflow or wrap beyond carry.
- Capture: on a rising edge with rst=0 and in_valid=1, sum and carry load the combinational result and out_valid is set to 1.
- Latency: exactly 1 cycle from the accepting edge. Throughput is one add per cycle, with no backpressure.
- Idle: on a rising edge with rst=0 and in_valid=0, sum and carry hold their previous values and out_valid is set to 0.
- Reset: on a rising edge with rst=1, sum=0, carry=0 and out_valid=0, regardless of in_valid or the operands.
  - Reset takes priority over capture.
  - A reset arriving mid-stream discards the in-flight result.
  - The first valid result after reset deasserts appears one cycle after the first accepting edge.
- X handling: operands are don't-care while in_valid=0. They must not corrupt the held outputs.
- No asynchronous paths from inputs to outputs; all outputs are driven directly by flops.

Test Plan:
- WIDTH=1 truth table, one row per cycle with in_valid=1. Inputs (a,b,cin) 000,001,010,011,100,101,110,111 -> next cycle (sum,carry) = 00,10,10,01,10,01,01,11, with out_valid=1 each cycle.
- Reset: apply a=1, b=1, cin=1, in_valid=1 with rst=1 -> after the edge sum=0, carry=0, out_valid=0. Deassert rst -> result 1,1 appears one cycle later.
- Hold: capture a=1, b=0, cin=0 (sum=1, carry=0), then drive in_valid=0 with a=1, b=1, cin=1 for 3 cycles -> sum stays 1, carry stays 0, out_valid=0.
- WIDTH=8 boundary cases:
  - a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, carry=1 (full ripple).
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, carry=1.
  - a=8'h00, b=8'h00, cin=0 -> sum=8'h00, carry=0.
- Back-to-back: alternate in_valid=1 inputs (0,1,1) and (1,1,0) every cycle for 10 cycles -> outputs alternate (0,1) and (0,1), each paired with out_valid=1, at 1-cycle latency.
- Random: 1000 cycles with WIDTH=8, random in_valid, a, b, cin and occasional rst -> every out_valid pulse matches {carry,sum} = a+b+cin of the accepted inputs, checked against a scoreboard.
